// File: rtl/irq_ctrl_pkg.sv
// Shared register map, constants and bus helpers for the irq_ctrl slave.
package irq_ctrl_pkg;

  localparam int MAX_IRQ        = 32;
  localparam int ACTIVE_VLD_BIT = 31;

  localparam logic [4:0] REG_PENDING = 5'h00;
  localparam logic [4:0] REG_ENABLE  = 5'h04;
  localparam logic [4:0] REG_MODE    = 5'h08;
  localparam logic [4:0] REG_FORCE   = 5'h0C;
  localparam logic [4:0] REG_ACTIVE  = 5'h10;

  typedef enum logic [2:0] {
    SEL_PENDING,
    SEL_ENABLE,
    SEL_MODE,
    SEL_FORCE,
    SEL_ACTIVE,
    SEL_NONE
  } reg_sel_e;

  // Word decode; the two byte-offset bits are don't-care.
  function automatic reg_sel_e reg_decode(input logic [4:0] a);
    logic [4:0] w;
    w = {a[4:2], 2'b00};
    case (w)
      REG_PENDING: return SEL_PENDING;
      REG_ENABLE:  return SEL_ENABLE;
      REG_MODE:    return SEL_MODE;
      REG_FORCE:   return SEL_FORCE;
      REG_ACTIVE:  return SEL_ACTIVE;
      default:     return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: {valid, index} of the first set request bit.
module irq_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = 5'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller on the picorv32 native bus.
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every irq_src bit.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ      = 8,
  parameter logic [31:0] RESET_ENABLE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               select,
  input  logic [3:0]         wstrb,
  input  logic [4:0]         addr,
  input  logic [31:0]        data_i,
  output logic               ready,
  output logic [31:0]        data_o,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [NUM_IRQ-1:0] irq_o
);

  logic               r_ready;
  logic [31:0]        r_data;
  logic [NUM_IRQ-1:0] r_pending, r_enable, r_mode, r_prev;
  logic [NUM_IRQ-1:0] w_src, w_edge, w_w1c, w_force, w_mask, w_wdata, w_pend_nxt;
  logic               w_acc, w_wr, w_rd, w_act_vld;
  logic [4:0]         w_act_idx;
  logic [31:0]        w_mask32, w_rdata;
  reg_sel_e           w_sel;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  // A transfer is accepted only when ready is low, so each select yields one pulse.
  assign w_acc    = select & ~r_ready;
  assign w_wr     = w_acc & (|wstrb);
  assign w_rd     = w_acc & ~(|wstrb);
  assign w_sel    = reg_decode(addr);
  assign w_mask32 = strb_mask(wstrb);
  assign w_mask   = w_mask32[NUM_IRQ-1:0];
  assign w_wdata  = data_i[NUM_IRQ-1:0] & w_mask;

  assign w_w1c   = (w_wr && w_sel == SEL_PENDING) ? w_wdata : '0;
  assign w_force = (w_wr && w_sel == SEL_FORCE)   ? w_wdata : '0;
  assign w_edge  = w_src & ~r_prev;

  // Sets (edge, level, force) are OR-ed after the W1C so they win a collision.
  assign w_pend_nxt = (r_mode & ((r_pending & ~w_w1c) | w_edge))
                    | (~r_mode & w_src)
                    | w_force;

  assign irq_o = r_pending & r_enable;

  irq_prio_enc #(.W(NUM_IRQ)) u_prio (
    .i_req   (irq_o),
    .o_valid (w_act_vld),
    .o_idx   (w_act_idx)
  );

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_PENDING: w_rdata = 32'(r_pending);
      SEL_ENABLE:  w_rdata = 32'(r_enable);
      SEL_MODE:    w_rdata = 32'(r_mode);
      SEL_ACTIVE: begin
        w_rdata[ACTIVE_VLD_BIT] = w_act_vld;
        w_rdata[4:0]            = w_act_idx;
      end
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_data    <= '0;
      r_pending <= '0;
      r_enable  <= RESET_ENABLE[NUM_IRQ-1:0];
      r_mode    <= '1;
      r_prev    <= '0;
    end else begin
      r_ready   <= w_acc;
      r_prev    <= w_src;
      r_pending <= w_pend_nxt;
      if (w_rd)      r_data <= w_rdata;
      else if (w_wr) r_data <= '0;
      if (w_wr && w_sel == SEL_ENABLE) r_enable <= (r_enable & ~w_mask) | w_wdata;
      if (w_wr && w_sel == SEL_MODE)   r_mode   <= (r_mode & ~w_mask) | w_wdata;
    end
  end

  assign ready  = r_ready;
  assign data_o = r_data;

endmodule
